// File: rtl/mem_wb_stage.sv
// MEM/WB boundary stage: retires one instruction per cycle into the regfile write port,
// stalling MEM while a load waits on the variable-latency data-RAM read handshake.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_is_load,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_signed,
  input  logic [1:0]        in_byte_off,
  output logic              ram_req,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_LOAD_WAIT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                ram_req_q, ram_req_d;
  logic                wb_we_q, wb_we_d;
  logic [ADDR_W-1:0]   wb_waddr_q, wb_waddr_d;
  logic [DATA_W-1:0]   wb_wdata_q, wb_wdata_d;
  logic                cap_we_q, cap_we_d;
  logic [ADDR_W-1:0]   cap_waddr_q, cap_waddr_d;
  logic [1:0]          cap_size_q, cap_size_d;
  logic                cap_signed_q, cap_signed_d;
  logic [1:0]          cap_off_q, cap_off_d;

  // Pick the addressed little-endian lane and extend it; half loads align down.
  function automatic logic [DATA_W-1:0] extract(input logic [1:0] size, input logic sgn,
                                                input logic [1:0] off,
                                                input logic [DATA_W-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   extract = {{(DATA_W-8){sgn & b[7]}}, b};
      2'b01:   extract = {{(DATA_W-16){sgn & h[15]}}, h};
      default: extract = rdata;
    endcase
  endfunction

  assign in_ready = (state_q == S_IDLE);
  assign ram_req  = ram_req_q;
  assign wb_we    = wb_we_q;
  assign wb_waddr = wb_waddr_q;
  assign wb_wdata = wb_wdata_q;

  // Next-state logic: accept, load wait, flush abort and write-pulse generation.
  always_comb begin
    state_d      = state_q;
    ram_req_d    = ram_req_q;
    wb_we_d      = 1'b0;
    wb_waddr_d   = wb_waddr_q;
    wb_wdata_d   = wb_wdata_q;
    cap_we_d     = cap_we_q;
    cap_waddr_d  = cap_waddr_q;
    cap_size_d   = cap_size_q;
    cap_signed_d = cap_signed_q;
    cap_off_d    = cap_off_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (in_valid && in_is_load) begin
          state_d      = S_LOAD_WAIT;
          ram_req_d    = 1'b1;
          cap_we_d     = in_we;
          cap_waddr_d  = in_waddr;
          cap_size_d   = in_ld_size;
          cap_signed_d = in_ld_signed;
          cap_off_d    = in_byte_off;
        end else if (in_valid && in_we && (in_waddr != {ADDR_W{1'b0}})) begin
          wb_we_d    = 1'b1;
          wb_waddr_d = in_waddr;
          wb_wdata_d = in_result;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_WAIT: begin
        // Flush wins over a same-cycle ack, so the load retires without writing.
        if (flush) begin
          state_d   = S_IDLE;
          ram_req_d = 1'b0;
        end else if (ram_ack) begin
          state_d   = S_IDLE;
          ram_req_d = 1'b0;
          if (cap_we_q && (cap_waddr_q != {ADDR_W{1'b0}})) begin
            wb_we_d    = 1'b1;
            wb_waddr_d = cap_waddr_q;
            wb_wdata_d = extract(cap_size_q, cap_signed_q, cap_off_q, ram_rdata);
          end else begin
            wb_we_d = 1'b0;
          end
        end else begin
          state_d = S_LOAD_WAIT;
        end
      end
      default: begin
        state_d   = S_IDLE;
        ram_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ram_req_q    <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_waddr_q   <= {ADDR_W{1'b0}};
      wb_wdata_q   <= {DATA_W{1'b0}};
      cap_we_q     <= 1'b0;
      cap_waddr_q  <= {ADDR_W{1'b0}};
      cap_size_q   <= 2'b00;
      cap_signed_q <= 1'b0;
      cap_off_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      ram_req_q    <= ram_req_d;
      wb_we_q      <= wb_we_d;
      wb_waddr_q   <= wb_waddr_d;
      wb_wdata_q   <= wb_wdata_d;
      cap_we_q     <= cap_we_d;
      cap_waddr_q  <= cap_waddr_d;
      cap_size_q   <= cap_size_d;
      cap_signed_q <= cap_signed_d;
      cap_off_q    <= cap_off_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_we, in_is_load, in_ld_signed;
  logic [4:0]  in_waddr, wb_waddr;
  logic [31:0] in_result, ram_rdata, wb_wdata;
  logic [1:0]  in_ld_size, in_byte_off;
  logic        ram_req, ram_ack, wb_we;

  int n_vec = 0;
  int n_err = 0;

  // Model: an optional pending load record plus the expected output registers.
  bit          m_pend;
  bit          m_we_cap;
  int unsigned m_waddr_cap, m_size, m_off;
  bit          m_signed;
  bit          e_we;
  int unsigned e_waddr, e_wdata;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_we(in_we), .in_waddr(in_waddr), .in_result(in_result), .in_is_load(in_is_load),
    .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed), .in_byte_off(in_byte_off),
    .ram_req(ram_req), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  function automatic int unsigned load_value(int unsigned size, bit sgn, int unsigned off,
                                             int unsigned rdata);
    int unsigned v;
    if (size == 0) begin
      v = (rdata >> (8 * off)) & 32'hFF;
      if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (rdata >> (8 * (off & 2))) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit wr;
    wr = 1'b0;
    if (rst) begin
      m_pend = 1'b0; e_waddr = 0; e_wdata = 0;
    end else if (!m_pend) begin
      if (!flush && in_valid) begin
        if (in_is_load) begin
          m_pend = 1'b1; m_we_cap = in_we; m_waddr_cap = in_waddr;
          m_size = in_ld_size; m_signed = in_ld_signed; m_off = in_byte_off;
        end else if (in_we && in_waddr != 0) begin
          wr = 1'b1; e_waddr = in_waddr; e_wdata = in_result;
        end
      end
    end else if (flush) begin
      m_pend = 1'b0;
    end else if (ram_ack) begin
      m_pend = 1'b0;
      if (m_we_cap && m_waddr_cap != 0) begin
        wr = 1'b1; e_waddr = m_waddr_cap;
        e_wdata = load_value(m_size, m_signed, m_off, ram_rdata);
      end
    end
    e_we = wr;
  endtask

  // One clock: advance the model with the applied inputs, then compare every output.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("wb_we",    {31'd0, wb_we},    {31'd0, e_we});
    chk("wb_waddr", {27'd0, wb_waddr}, e_waddr);
    chk("wb_wdata", wb_wdata,          e_wdata);
    chk("ram_req",  {31'd0, ram_req},  {31'd0, m_pend});
    chk("in_ready", {31'd0, in_ready}, {31'd0, !m_pend});
  endtask

  task automatic idle_in();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_waddr = 5'd0;
    in_result = 32'd0; in_is_load = 1'b0; in_ld_size = 2'b00; in_ld_signed = 1'b0;
    in_byte_off = 2'b00; ram_ack = 1'b0; ram_rdata = 32'd0;
  endtask

  task automatic drive_op(input bit ld, input bit we, input logic [4:0] wa,
                          input logic [31:0] res, input logic [1:0] sz, input bit sg,
                          input logic [1:0] off);
    idle_in();
    in_valid = 1'b1; in_is_load = ld; in_we = we; in_waddr = wa; in_result = res;
    in_ld_size = sz; in_ld_signed = sg; in_byte_off = off;
  endtask

  task automatic ack_with(input logic [31:0] d);
    idle_in();
    ram_ack = 1'b1; ram_rdata = d;
  endtask

  initial begin
    m_pend = 1'b0; e_we = 1'b0; e_waddr = 0; e_wdata = 0;
    idle_in();
    rst = 1'b1;
    step(); step();
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_wdata", wb_wdata, 32'd0);

    drive_op(1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 2'b00, 1'b0, 2'b00); step();
    chk("nl_we", {31'd0, wb_we}, 32'd1);
    chk("nl_waddr", {27'd0, wb_waddr}, 32'd3);
    chk("nl_wdata", wb_wdata, 32'hDEAD_BEEF);
    idle_in(); step();
    chk("nl_pulse_end", {31'd0, wb_we}, 32'd0);

    for (int i = 1; i <= 3; i++) begin
      drive_op(1'b0, 1'b1, i[4:0], 32'h1000 + i, 2'b00, 1'b0, 2'b00); step();
      chk("b2b_we", {31'd0, wb_we}, 32'd1);
      chk("b2b_wdata", wb_wdata, 32'h1000 + i);
      chk("b2b_ready", {31'd0, in_ready}, 32'd1);
    end

    drive_op(1'b1, 1'b1, 5'd4, 32'd0, 2'b00, 1'b1, 2'b10); step();
    chk("lb_ready_wait", {31'd0, in_ready}, 32'd0);
    chk("lb_req", {31'd0, ram_req}, 32'd1);
    idle_in(); step(); step();
    ack_with(32'h1280_5634); step();
    chk("lb_we", {31'd0, wb_we}, 32'd1);
    chk("lb_wdata", wb_wdata, 32'hFFFF_FF80);

    drive_op(1'b1, 1'b1, 5'd5, 32'd0, 2'b01, 1'b0, 2'b11); step();
    ack_with(32'h8001_7FFF); step();
    chk("lh_wdata", wb_wdata, 32'h0000_8001);
    drive_op(1'b1, 1'b1, 5'd6, 32'd0, 2'b10, 1'b1, 2'b01); step();
    ack_with(32'hCAFE_F00D); step();
    chk("lw_wdata", wb_wdata, 32'hCAFE_F00D);

    drive_op(1'b1, 1'b1, 5'd7, 32'd0, 2'b10, 1'b0, 2'b00); step();
    idle_in(); step();
    flush = 1'b1; step();
    chk("fl_req", {31'd0, ram_req}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    ack_with(32'h5555_AAAA); step();
    chk("fl_late_ack_we", {31'd0, wb_we}, 32'd0);

    drive_op(1'b0, 1'b1, 5'd0, 32'h1234_5678, 2'b00, 1'b0, 2'b00); step();
    chk("r0_we", {31'd0, wb_we}, 32'd0);

    drive_op(1'b1, 1'b1, 5'd9, 32'd0, 2'b10, 1'b0, 2'b00); step();
    ack_with(32'h7777_7777); rst = 1'b1; step();
    chk("rstld_we", {31'd0, wb_we}, 32'd0);
    chk("rstld_waddr", {27'd0, wb_waddr}, 32'd0);
    chk("rstld_req", {31'd0, ram_req}, 32'd0);
    ack_with(32'h7777_7777); step();
    chk("rstld_after_we", {31'd0, wb_we}, 32'd0);

    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      in_valid     = $urandom_range(0, 1);
      in_is_load   = ($urandom_range(0, 2) == 0);
      in_we        = ($urandom_range(0, 4) != 0);
      in_waddr     = 5'($urandom_range(0, 31));
      in_result    = $urandom;
      in_ld_size   = 2'($urandom_range(0, 3));
      in_ld_signed = $urandom_range(0, 1);
      in_byte_off  = 2'($urandom_range(0, 3));
      ram_ack      = ($urandom_range(0, 2) == 0);
      ram_rdata    = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
